// File: rtl/ccff_loader.sv
// ----------------------------------------------------------------------------
// ccff_loader
//
// Serial loader for a configuration flip-flop (ccff) chain. Configuration
// bytes arrive on a valid/ready stream and are shifted LSB-first into the
// chain head, one bit per prog_clk cycle, until exactly CHAIN_LEN bits have
// been shifted. Byte 0 is shifted first. Only the low bits of the final byte
// that fit the chain are used, and its upper bits are discarded.
//
// Optional feature (macro CCFF_READBACK_EN): after the load, the chain is
// recirculated once (tail fed back into head). The recirculated bits are
// packed LSB-first into bytes on out_data/out_valid/out_ready. Without the
// macro, out_data/out_valid are tied to 0 and out_ready is ignored.
//
// Parameters
//   CHAIN_LEN      number of flops in the target chain (1..65535)
//
// Ports
//   prog_clk       programming clock; all state changes on its rising edge
//   pReset         synchronous active-high reset
//   start          one-cycle load request (ignored while busy)
//   in_data[7:0]   configuration byte
//   in_valid       in_data valid
//   in_ready       byte accepted when in_valid && in_ready
//   ccff_head      serial bit into the chain head
//   ccff_shift_en  chain captures ccff_head at the end of a cycle where this is 1
//   ccff_tail      serial bit out of the chain tail
//   out_data[7:0]  readback byte (0 without CCFF_READBACK_EN)
//   out_valid      readback byte valid (0 without CCFF_READBACK_EN)
//   out_ready      readback consumer ready
//   busy           high in any state other than IDLE
//   done           one-cycle completion pulse
// ----------------------------------------------------------------------------
module ccff_loader #(
    parameter int CHAIN_LEN = 64
) (
    input  logic       prog_clk,
    input  logic       pReset,
    input  logic       start,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       ccff_head,
    output logic       ccff_shift_en,
    input  logic       ccff_tail,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy,
    output logic       done
);
    localparam int NB        = (CHAIN_LEN + 7) / 8;
    localparam int LAST_BITS = CHAIN_LEN - 8 * (NB - 1);
    localparam int BW        = $clog2(CHAIN_LEN + 1);
    localparam int NBW       = $clog2(NB + 1);

    localparam logic [BW-1:0]  LAST_BIT_IDX   = BW'(CHAIN_LEN - 1);
    localparam logic [NBW-1:0] NB_L           = NBW'(NB);
    localparam logic [NBW-1:0] LAST_BYTE_IDX  = NBW'(NB - 1);
    localparam logic [3:0]     LAST_BYTE_BITS = 4'(LAST_BITS);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_LOAD     = 2'd1;
`ifdef CCFF_READBACK_EN
    localparam logic [1:0] S_READBACK = 2'd2;
`endif
    localparam logic [1:0] S_DONE     = 2'd3;

    logic [1:0]     state;
    logic [7:0]     shift_buf;   // bit 0 is the next bit to leave
    logic [3:0]     buf_cnt;     // bits still to shift out of shift_buf
    logic [NBW-1:0] byte_cnt;    // bytes accepted in this load
    logic [BW-1:0]  bit_cnt;     // bits shifted into the chain in this load

    logic load_shift;
    logic accept;
    logic load_last;
    logic rb_shift;

    // NOTE: shifting is gated by pReset so that the reset edge itself never
    // moves the chain; without this the chain would capture one more bit on
    // the edge that aborts the load.
    always_comb begin
        load_shift = (state == S_LOAD) && (buf_cnt != 4'd0) && !pReset;
        // buf_cnt == 1 means the last buffered bit leaves this cycle, so the
        // next byte can be loaded in the same cycle for back-to-back bytes.
        in_ready   = (state == S_LOAD) && (buf_cnt <= 4'd1) && (byte_cnt < NB_L) && !pReset;
        accept     = in_valid && in_ready;
        load_last  = load_shift && (bit_cnt == LAST_BIT_IDX);
    end

`ifdef CCFF_READBACK_EN
    localparam logic [BW-1:0] CHAIN_LEN_L = BW'(CHAIN_LEN);

    logic [BW-1:0] rb_cnt;    // bits recirculated so far
    logic [2:0]    rb_idx;    // next bit position in rb_data
    logic [7:0]    rb_data;
    logic          rb_valid;
    logic          rb_hs;

    assign rb_shift = (state == S_READBACK) && !rb_valid && (rb_cnt != CHAIN_LEN_L) && !pReset;
    assign rb_hs    = rb_valid && out_ready;

    always_ff @(posedge prog_clk) begin
        if (pReset || (state == S_IDLE)) begin
            rb_cnt   <= '0;
            rb_idx   <= '0;
            rb_data  <= '0;
            rb_valid <= 1'b0;
        end else if (rb_shift) begin
            rb_data[rb_idx] <= ccff_tail;
            rb_idx          <= rb_idx + 3'd1;
            rb_cnt          <= rb_cnt + 1'b1;
            // A full byte, or the final partial byte (its upper bits stay 0).
            if ((rb_idx == 3'd7) || (rb_cnt == LAST_BIT_IDX)) begin
                rb_valid <= 1'b1;
            end
        end else if (rb_hs) begin
            rb_valid <= 1'b0;
            rb_data  <= '0;
            rb_idx   <= '0;
        end
    end

    assign out_data  = rb_data;
    assign out_valid = rb_valid;
`else
    assign rb_shift  = 1'b0;
    assign out_data  = 8'h00;
    assign out_valid = 1'b0;

    logic unused_inputs;
    assign unused_inputs = ^{ccff_tail, out_ready};
`endif

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            state     <= S_IDLE;
            shift_buf <= '0;
            buf_cnt   <= '0;
            byte_cnt  <= '0;
            bit_cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_LOAD;
                        shift_buf <= '0;
                        buf_cnt   <= '0;
                        byte_cnt  <= '0;
                        bit_cnt   <= '0;
                    end
                end
                S_LOAD: begin
                    if (accept) begin
                        shift_buf <= in_data;
                        buf_cnt   <= (byte_cnt == LAST_BYTE_IDX) ? LAST_BYTE_BITS : 4'd8;
                        byte_cnt  <= byte_cnt + 1'b1;
                    end else if (load_shift) begin
                        shift_buf <= shift_buf >> 1;
                        buf_cnt   <= buf_cnt - 4'd1;
                    end
                    if (load_shift) begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                    if (load_last) begin
`ifdef CCFF_READBACK_EN
                        state <= S_READBACK;
`else
                        state <= S_DONE;
`endif
                    end
                end
`ifdef CCFF_READBACK_EN
                S_READBACK: begin
                    if (rb_hs && (rb_cnt == CHAIN_LEN_L)) begin
                        state <= S_DONE;
                    end
                end
`endif
                default: state <= S_IDLE;   // DONE lasts exactly one cycle
            endcase
        end
    end

    // NOTE: the default assignment first keeps this combinational block from
    // inferring a latch on paths that do not drive ccff_head.
    always_comb begin
        ccff_head = 1'b0;
        if (load_shift) begin
            ccff_head = shift_buf[0];
        end
`ifdef CCFF_READBACK_EN
        else if (state == S_READBACK) begin
            ccff_head = ccff_tail;
        end
`endif
    end

    assign ccff_shift_en = load_shift || rb_shift;
    assign busy          = (state != S_IDLE);
    assign done          = (state == S_DONE);

endmodule
